seg_scanner: RTL and testbench

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_scanner.sv | 109 ++++++++++
 tb/tb_seg_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed driver for a six-digit seven-segment display.
// Latency: seg/an/frame_start are registered, one clk after the slot position they describe.
// Backpressure: none; the scan free-runs and freeze only holds the captured frame.
// Optional feature macro SCAN_BLANK_EN: blanks the first BLANK cycles of every slot.
module seg_scanner #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int              CW      = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  // Reject parameter values the counters cannot honour.
  if (DIV < 4 || DIV > (1 << 20)) begin : g_bad_div
    $error("seg_scanner: DIV out of range");
  end
  if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
    $error("seg_scanner: BLANK out of range");
  end

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [6:0]    shadow [6];

  logic          cnt_wrap;
  logic          frame_first;
  logic          capture;
  logic [6:0]    pat;
  logic [5:0]    vis_an;

  assign cnt_wrap    = (cnt == CNT_MAX);
  assign frame_first = (idx == 3'd0) && (cnt == '0);
  // A frozen frame start keeps the old shadow for the whole next frame.
  assign capture     = frame_first && !freeze;
  assign vis_an      = ~(6'b000001 << idx);

  // Select the held pattern for the digit currently being scanned.
  always_comb begin
    pat = 7'h00;
    case (idx)
      3'd0:    pat = shadow[0];
      3'd1:    pat = shadow[1];
      3'd2:    pat = shadow[2];
      3'd3:    pat = shadow[3];
      3'd4:    pat = shadow[4];
      3'd5:    pat = shadow[5];
      default: pat = 7'h00;
    endcase
  end

`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
`endif

  // Slot/digit counters, frame capture and registered display drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 3'd0;
      for (int i = 0; i < 6; i++) shadow[i] <= 7'h00;
      seg         <= 7'h00;
      an          <= 6'b111111;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

      // All six digits load on the same edge so a frame never mixes old and new data.
      if (capture) begin
        shadow[0] <= d1;
        shadow[1] <= d2;
        shadow[2] <= d3;
        shadow[3] <= d4;
        shadow[4] <= d5;
        shadow[5] <= d6;
      end

      frame_start <= frame_first;

`ifdef SCAN_BLANK_EN
      if (cnt < BLANK_C) begin
        an  <= 6'b111111;
        seg <= 7'h00;
      end else begin
        an  <= vis_an;
        seg <= capture ? d1 : pat;
      end
`else
      // Digit 0 on a capture edge bypasses the shadow so the fresh value shows at once.
      an  <= vis_an;
      seg <= capture ? d1 : pat;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: checks seg_scanner (DIV=4, BLANK=1) against a frame-level model.
// Latency: outputs compared at the falling edge after each rising edge.
// Backpressure: not applicable.
module tb_seg_scanner;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 6 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] d1 = 7'h7E, d2 = 7'h30, d3 = 7'h6D, d4 = 7'h79, d5 = 7'h33, d6 = 7'h5B;
  logic       freeze = 1'b0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .freeze(freeze), .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: position inside the frame is derived from the number of
  // edges since reset released; the displayed frame is latched at frame start.
  int         n = 0;
  logic [6:0] fp [6];
  logic [6:0] exp_seg = 7'h00;
  logic [5:0] exp_an  = 6'b111111;
  logic       exp_fs  = 1'b0;

  always @(posedge clk) begin
    int pos, slot, c;
    if (reset) begin
      n = 0;
      for (int i = 0; i < 6; i++) fp[i] = 7'h00;
      exp_seg = 7'h00; exp_an = 6'b111111; exp_fs = 1'b0;
    end else begin
      pos  = n % FRAME;
      slot = pos / DIV;
      c    = pos % DIV;
      if (pos == 0 && !freeze) begin
        fp[0] = d1; fp[1] = d2; fp[2] = d3; fp[3] = d4; fp[4] = d5; fp[5] = d6;
      end
      exp_fs = (pos == 0);
      exp_an = 6'b111111;
      exp_an[slot] = 1'b0;
      exp_seg = fp[slot];
`ifdef SCAN_BLANK_EN
      if (c < BLANK) begin
        exp_an = 6'b111111; exp_seg = 7'h00;
      end
`endif
      n = n + 1;
    end
  end

  // Every cycle: at most one digit enabled, and frames are exactly FRAME edges apart.
  int cyc = 0, last_fs = 0;
  bit fs_valid = 0;
  always @(posedge clk) begin
    logic r;
    r = reset;
    cyc = cyc + 1;
    #2;
    n_checks++;
    if ($countones(~an) > 1) begin
      n_fail++;
      $display("FAIL onehot cyc=%0d an=%b required at most one zero", cyc, an);
    end
    if (r) fs_valid = 0;
    else if (frame_start === 1'b1) begin
      if (fs_valid) begin
        n_checks++;
        if (cyc - last_fs != FRAME) begin
          n_fail++;
          $display("FAIL period cyc=%0d got %0d required %0d", cyc, cyc - last_fs, FRAME);
        end
      end
      last_fs = cyc;
      fs_valid = 1;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, an, seg} !== {1'b0, 6'b111111, 7'h00}) begin
        n_fail++;
        $display("FAIL reset got fs=%b an=%b seg=%h required 0/111111/00", frame_start, an, seg);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, an, seg} !== {exp_fs, exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL scan e=%0d got %b/%b/%h required %b/%b/%h", e, frame_start, an, seg, exp_fs, exp_an, exp_seg);
      end
      if (e == 1) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL scan_first_fs got %b required 1", frame_start);
        end
      end
      if (e == 2) begin
        n_checks++;
        if ({an, seg} !== {6'b111110, 7'h7E}) begin
          n_fail++;
          $display("FAIL scan_digit0 got %b/%h required 111110/7e", an, seg);
        end
      end
    end
    d3 = 7'h7F;
  endtask

  task automatic test_input_change();
    for (int e = 7; e <= 24; e++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, an, seg} !== {exp_fs, exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL change e=%0d got %b/%b/%h required %b/%b/%h", e, frame_start, an, seg, exp_fs, exp_an, exp_seg);
      end
      if (e == 10 || e == 24) begin
        n_checks++;
        if ({an, seg} !== ((e == 10) ? {6'b111011, 7'h6D} : {6'b011111, 7'h5B})) begin
          n_fail++;
          $display("FAIL change_const e=%0d got %b/%h", e, an, seg);
        end
      end
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    d1 = 7'h00;
    for (int e = 25; e <= 60; e++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, an, seg} !== {exp_fs, exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL freeze e=%0d got %b/%b/%h required %b/%b/%h", e, frame_start, an, seg, exp_fs, exp_an, exp_seg);
      end
      if (e == 25) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL freeze_fs got %b required 1", frame_start);
        end
      end
      if (e >= 26 && e <= 28) begin
        n_checks++;
        if ({an, seg} !== {6'b111110, 7'h7E}) begin
          n_fail++;
          $display("FAIL freeze_hold e=%0d got %b/%h required 111110/7e", e, an, seg);
        end
      end
      if (e == 36 || e == 50 || e == 58) begin
        n_checks++;
        if (seg !== ((e == 36) ? 7'h6D : (e == 50) ? 7'h00 : 7'h7F)) begin
          n_fail++;
          $display("FAIL freeze_after e=%0d got seg=%h", e, seg);
        end
      end
      if (e == 28) freeze = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({frame_start, an, seg} !== {1'b0, 6'b111111, 7'h00}) begin
      n_fail++;
      $display("FAIL midreset got %b/%b/%h required 0/111111/00", frame_start, an, seg);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({frame_start, an} !== {1'b1, 6'b111110}) begin
      n_fail++;
      $display("FAIL midreset_restart got fs=%b an=%b required 1/111110", frame_start, an);
    end
    n_checks++;
    if ({frame_start, an, seg} !== {exp_fs, exp_an, exp_seg}) begin
      n_fail++;
      $display("FAIL midreset_model got %b/%b/%h required %b/%b/%h", frame_start, an, seg, exp_fs, exp_an, exp_seg);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, an, seg} !== {exp_fs, exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL random k=%0d got %b/%b/%h required %b/%b/%h", k, frame_start, an, seg, exp_fs, exp_an, exp_seg);
      end
      if ($urandom_range(7) == 0) begin
        d1 = 7'($urandom); d2 = 7'($urandom); d3 = 7'($urandom);
        d4 = 7'($urandom); d5 = 7'($urandom); d6 = 7'($urandom);
      end
      freeze = ($urandom_range(3) == 0);
      reset  = ($urandom_range(59) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_input_change();
    test_freeze();
    test_reset_midframe();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
